// File: rtl/hazard_scheduler.sv
// Issue-side scoreboard and jump-flush sequencer: stalls decode on pending operands,
// forces bubbles after a jump, counts stall cycles. Optional feature macro: PIGRO_BYPASS_EN.
module hazard_scheduler #(
    parameter int NREG      = 16,
    parameter int LAT       = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [3:0]  issue_ra,
    input  logic [3:0]  issue_rb,
    input  logic        issue_use_b,
    input  logic        issue_wr,
    input  logic [3:0]  issue_rd,
    input  logic        jump_req,
    input  logic [4:0]  jump_dest,
    output logic        issue_ack,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [4:0]  redirect_pc,
    output logic [15:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam int CW = $clog2(LAT + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] LAT_C   = CW'(LAT);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_CYC);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            redirect_q, redirect_d;
    logic [4:0]      redirect_pc_q, redirect_pc_d;
    logic [15:0]     busy_q, busy_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            busy_a_s, busy_b_s, hz_s, run_s, stall_s, ack_s;

    // Operand hazard detection and the combinational handshake.
    always_comb begin
`ifdef PIGRO_BYPASS_EN
        // Forwarding covers everything except a producer still sitting in EX.
        busy_a_s = (cnt_q[issue_ra] == LAT_C);
        busy_b_s = (cnt_q[issue_rb] == LAT_C);
`else
        busy_a_s = (cnt_q[issue_ra] != {CW{1'b0}});
        busy_b_s = (cnt_q[issue_rb] != {CW{1'b0}});
`endif
        hz_s    = busy_a_s | (issue_use_b & busy_b_s);
        run_s   = (state_q == RUN) & rst;
        stall_s = issue_valid & hz_s & run_s;
        ack_s   = issue_valid & ~hz_s & run_s;
    end

    // Flush sequencer next-state and redirect capture.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            RUN: begin
                if (ack_s & jump_req) begin
                    state_d       = FLUSH;
                    fcnt_d        = FLUSH_C;
                    redirect_d    = 1'b1;
                    redirect_pc_d = jump_dest;
                end else begin
                    fcnt_d = {FW{1'b0}};
                end
            end
            FLUSH: begin
                if (fcnt_q <= FW'(1)) begin
                    state_d = RUN;
                    fcnt_d  = {FW{1'b0}};
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = {FW{1'b0}};
            end
        endcase
    end

    // Scoreboard countdown; an accepted jump never claims its destination.
    always_comb begin
        busy_d = 16'h0000;
        for (int r = 0; r < NREG; r++) begin
            if (ack_s & issue_wr & ~jump_req & (issue_rd == 4'(r))) begin
                cnt_d[r] = LAT_C;
            end else if (cnt_q[r] != {CW{1'b0}}) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end else begin
                cnt_d[r] = {CW{1'b0}};
            end
            busy_d[r] = (cnt_d[r] != {CW{1'b0}});
        end
    end

    // Saturating stall counter.
    always_comb begin
        if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fcnt_q        <= {FW{1'b0}};
            redirect_q    <= 1'b0;
            redirect_pc_q <= 5'd0;
            busy_q        <= 16'h0000;
            stall_cnt_q   <= 16'h0000;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= {CW{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            busy_q        <= busy_d;
            stall_cnt_q   <= stall_cnt_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign issue_ack   = ack_s;
    assign stall       = stall_s;
    assign flush       = (state_q == FLUSH);
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign busy_mask   = busy_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: a cycle-time reference model plus
// directed literal checks and randomized traffic.
module tb_hazard_scheduler;

    localparam int LAT       = 3;
    localparam int FLUSH_CYC = 2;
`ifdef PIGRO_BYPASS_EN
    localparam int NSTALL = 1;
`else
    localparam int NSTALL = LAT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_ra = 4'd0, issue_rb = 4'd0, issue_rd = 4'd0;
    logic        issue_use_b = 1'b0, issue_wr = 1'b0, jump_req = 1'b0;
    logic [4:0]  jump_dest = 5'd0;
    logic        issue_ack, stall, flush, redirect;
    logic [4:0]  redirect_pc;
    logic [15:0] busy_mask, stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_scheduler dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ra(issue_ra),
        .issue_rb(issue_rb), .issue_use_b(issue_use_b), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .jump_req(jump_req), .jump_dest(jump_dest),
        .issue_ack(issue_ack), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model in absolute cycle numbers: a register written at cycle t is
    // pending during t+1..t+LAT; a jump accepted at t flushes t+1..t+FLUSH_CYC.
    int          cyc = 0;
    int          last_iss [16];
    int          jump_c, flush_last, m_stall_cnt;
    logic [4:0]  m_pc;

    function automatic logic pend(input int r);
        return cyc <= last_iss[r] + LAT;
    endfunction

    function automatic logic rd_busy(input int r);
`ifdef PIGRO_BYPASS_EN
        return cyc == last_iss[r] + 1;
`else
        return pend(r);
`endif
    endfunction

    always @(negedge clk) begin
        logic        hz, in_fl, e_stall, e_ack;
        logic [15:0] e_mask;
        #2;
        if (!rst) begin
            for (int r = 0; r < 16; r++) last_iss[r] = -1000;
            jump_c = -1000; flush_last = -1000; m_stall_cnt = 0; m_pc = 5'd0;
            chk("rst_ack", int'(issue_ack), 0);
            chk("rst_stall", int'(stall), 0);
            chk("rst_flush", int'(flush), 0);
            chk("rst_redirect", int'(redirect), 0);
            chk("rst_pc", int'(redirect_pc), 0);
            chk("rst_busy", int'(busy_mask), 0);
            chk("rst_stall_cnt", int'(stall_cnt), 0);
        end else begin
            in_fl   = cyc <= flush_last;
            hz      = rd_busy(int'(issue_ra)) | (issue_use_b & rd_busy(int'(issue_rb)));
            e_stall = issue_valid & hz & ~in_fl;
            e_ack   = issue_valid & ~hz & ~in_fl;
            for (int r = 0; r < 16; r++) e_mask[r] = pend(r);
            chk("ack", int'(issue_ack), int'(e_ack));
            chk("stall", int'(stall), int'(e_stall));
            chk("flush", int'(flush), int'(in_fl));
            chk("redirect", int'(redirect), int'(cyc == jump_c + 1));
            chk("redirect_pc", int'(redirect_pc), int'(m_pc));
            chk("busy_mask", int'(busy_mask), int'(e_mask));
            chk("stall_cnt", int'(stall_cnt), m_stall_cnt);
            if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
            if (e_ack) begin
                if (jump_req) begin
                    jump_c = cyc; flush_last = cyc + FLUSH_CYC; m_pc = jump_dest;
                end else if (issue_wr) begin
                    last_iss[issue_rd] = cyc;
                end
            end
        end
        cyc++;
    end

    task automatic drive(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                         input logic ub, input logic wr, input logic [3:0] rd,
                         input logic j, input logic [4:0] jd);
        @(negedge clk);
        issue_valid = v; issue_ra = ra; issue_rb = rb; issue_use_b = ub;
        issue_wr = wr; issue_rd = rd; jump_req = j; jump_dest = jd;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);
        chk("t1_busy", int'(busy_mask), 0);
        chk("t1_flush", int'(flush), 0);

        // RAW dependency on r2.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 5'd0);
        chk("t2_ack0", int'(issue_ack), 1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
            chk("t2_stall", int'(stall), int'(k <= NSTALL));
            chk("t2_ack", int'(issue_ack), int'(k > NSTALL));
        end
        idle(1);
        chk("t2_stall_cnt", int'(stall_cnt), NSTALL);
        idle(4);

        // Jump to 17 carrying a (to be ignored) write of r7.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 5'd17);
        chk("t4_ack", int'(issue_ack), 1);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        chk("t4_redirect", int'(redirect), 1);
        chk("t4_pc", int'(redirect_pc), 17);
        chk("t4_flush1", int'(flush), 1);
        chk("t4_ack_fl", int'(issue_ack), 0);
        chk("t4_busy", int'(busy_mask), 0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        chk("t4_flush2", int'(flush), 1);
        chk("t4_redirect2", int'(redirect), 0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        chk("t4_flush3", int'(flush), 0);
        chk("t4_ack3", int'(issue_ack), 1);
        idle(2);

        // WAW on r4.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 5'd0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 5'd0);
        chk("t5_ack", int'(issue_ack), 1);
        idle(3);
        chk("t5_busy_t4", int'(busy_mask[4]), 1);
        idle(1);
        chk("t5_busy_t5", int'(busy_mask[4]), 0);
        idle(2);

        // Reset in the middle of a flush with a register still pending.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 5'd0);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd3);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0);
        chk("t6_flush_pre", int'(flush), 1);
        chk("t6_busy_pre", int'(busy_mask[9]), 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_flush", int'(flush), 0);
        chk("t6_redirect", int'(redirect), 0);
        chk("t6_busy", int'(busy_mask), 0);
        chk("t6_stall_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b1; issue_ra = 4'd9; issue_wr = 1'b0; jump_req = 1'b0;
        #3;
        chk("t6_run", int'(issue_ack), 1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ra, rb, rd;
            ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 9) < 8), ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), rd, 1'($urandom_range(0, 9) == 0),
                  5'($urandom_range(0, 31)));
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
